// File: rtl/word_packer_pkg.sv
// word_packer_pkg: shared state encoding, default widths and sizing helper
// for the byte-to-word packer that feeds the write side of a dual-clock FIFO.
package word_packer_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned LEN_BITS_DEF   = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Byte-lane index width; a one-byte word still needs a 1-bit index.
    function automatic int unsigned idx_width(input int unsigned data_width);
        return (data_width / 8 > 1) ? $clog2(data_width / 8) : 1;
    endfunction

endpackage

// File: rtl/word_packer_if.sv
// word_packer_if: bundles the packer's control, upstream byte stream and
// downstream FIFO write-side signals.
//   master : environment side (drives start/block_size/bytes/fifo_full)
//   slave  : packer side (drives byte_ready/fifo_data/fifo_write_enable/busy/done)
interface word_packer_if
    import word_packer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned LEN_BITS   = LEN_BITS_DEF
);

    logic                  start;
    logic [LEN_BITS-1:0]   block_size;
    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  fifo_full;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_write_enable;
    logic                  busy;
    logic                  done;

    modport master (
        output start, block_size, byte_in, byte_valid, fifo_full,
        input  byte_ready, fifo_data, fifo_write_enable, busy, done
    );

    modport slave (
        input  start, block_size, byte_in, byte_valid, fifo_full,
        output byte_ready, fifo_data, fifo_write_enable, busy, done
    );

endinterface

// File: rtl/word_packer.sv
// word_packer: collects a block of block_size bytes (first byte in the LSBs)
// into DATA_WIDTH-bit words and writes each word once into a dual-clock FIFO,
// zero-padding a partial final word and pulsing done at the end.
//   write_clock : FIFO write-side clock, rising edge
//   reset       : asynchronous, active-high
//   bus         : word_packer_if.slave (start/block_size, byte stream,
//                 FIFO write port, busy/done status)
module word_packer
    import word_packer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned LEN_BITS   = LEN_BITS_DEF
)
(
    input  logic          write_clock,
    input  logic          reset,
    word_packer_if.slave  bus
);

    localparam int unsigned BPW   = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = idx_width(DATA_WIDTH);

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] word, word_next;
    logic [IDX_W-1:0]      idx, idx_next;
    logic [LEN_BITS-1:0]   remaining, remaining_next;

    // State and datapath registers.
    always_ff @(posedge write_clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            word      <= '0;
            idx       <= '0;
            remaining <= '0;
        end else begin
            state     <= state_next;
            word      <= word_next;
            idx       <= idx_next;
            remaining <= remaining_next;
        end
    end

    // Next-state, datapath updates and state-decoded outputs.
    always_comb begin
        state_next            = state;
        word_next             = word;
        idx_next              = idx;
        remaining_next        = remaining;
        bus.byte_ready        = 1'b0;
        bus.fifo_write_enable = 1'b0;
        bus.busy              = (state != ST_IDLE);
        bus.done              = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.block_size != '0) begin
                        remaining_next = bus.block_size;
                        idx_next       = '0;
                        word_next      = '0;
                        state_next     = ST_COLLECT;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end

            ST_COLLECT: begin
                bus.byte_ready = 1'b1;
                if (bus.byte_valid) begin
                    // Word was cleared on entry, so unfilled lanes stay zero.
                    word_next[{idx, 3'b000} +: 8] = bus.byte_in;
                    idx_next       = idx + IDX_W'(1);
                    remaining_next = remaining - LEN_BITS'(1);
                    if (idx == IDX_W'(BPW - 1) || remaining == LEN_BITS'(1)) begin
                        state_next = ST_WRITE;
                    end
                end
            end

            ST_WRITE: begin
                // Strobe follows fifo_full combinationally; a full FIFO freezes everything.
                bus.fifo_write_enable = ~bus.fifo_full;
                if (!bus.fifo_full) begin
                    if (remaining == '0) begin
                        state_next = ST_DONE;
                    end else begin
                        word_next  = '0;
                        idx_next   = '0;
                        state_next = ST_COLLECT;
                    end
                end
            end

            ST_DONE: begin
                bus.done   = 1'b1;
                state_next = ST_IDLE;
            end

            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.fifo_data = word;

endmodule

// File: tb/tb_word_packer.sv
// tb_word_packer: directed and randomized transfers through word_packer,
// checked against a byte-list packing model and transfer-level timing rules.
module tb_word_packer;
    import word_packer_pkg::*;

    localparam int unsigned DW  = DATA_WIDTH_DEF;
    localparam int unsigned LB  = LEN_BITS_DEF;
    localparam int unsigned BPW = DW / 8;

    typedef logic [7:0] byte_q_t[$];

    logic write_clock;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    word_packer_if #(.DATA_WIDTH(DW), .LEN_BITS(LB)) bus ();

    word_packer #(.DATA_WIDTH(DW), .LEN_BITS(LB)) dut (
        .write_clock (write_clock),
        .reset       (reset),
        .bus         (bus)
    );

    initial begin
        write_clock = 1'b0;
        forever #5 write_clock = ~write_clock;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic byte_q_t seq_bytes(input logic [7:0] first, input int n);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back(8'(first + 8'(i)));
        return q;
    endfunction

    function automatic byte_q_t rand_bytes(input int n);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Runs one transfer and compares FIFO writes with the packed byte list.
    task automatic run_transfer(input string name, input byte_q_t bytes, input int valid_pct,
                                input int full_pct, input int stall_cycles, input bit poke_start);
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] got_q[$];
        logic [DW-1:0] w;
        logic [DW-1:0] held;
        bit held_ok    = 1'b0;
        bit seen_done  = 1'b0;
        bit prev_we    = 1'b0;
        bit in_write;
        int n          = bytes.size();
        int ptr        = 0;
        int cycles     = 0;
        int stall_left = stall_cycles;
        int budget     = 50 * n + 200;

        // Reference: consecutive groups of BPW bytes, first byte lowest, zero padded.
        for (int base = 0; base < n; base += int'(BPW)) begin
            w = '0;
            for (int b = 0; b < int'(BPW); b++) begin
                if (base + b < n) w[8*b +: 8] = bytes[base + b];
            end
            exp_q.push_back(w);
        end

        for (cycles = 0; cycles < budget && !seen_done; cycles++) begin
            @(posedge write_clock);
            #1;
            in_write         = bus.busy && !bus.byte_ready && !bus.done;
            bus.start        = (cycles == 0) ? 1'b1 : (poke_start && ($urandom_range(3) == 0));
            bus.block_size   = (cycles == 0) ? LB'(n) : LB'($urandom_range(1, 20));
            bus.byte_valid   = (ptr < n) && (int'($urandom_range(99)) < valid_pct);
            bus.byte_in      = (ptr < n) ? bytes[ptr] : 8'($urandom);
            if (in_write && stall_left > 0) begin
                bus.fifo_full = 1'b1;
                stall_left--;
            end else begin
                bus.fifo_full = (int'($urandom_range(99)) < full_pct);
            end

            @(negedge write_clock);
            if (bus.byte_valid && bus.byte_ready) ptr++;
            if (bus.fifo_write_enable) begin
                check({name, ":ready_during_write"}, 64'(bus.byte_ready), 64'(0));
                got_q.push_back(bus.fifo_data);
            end
            if (bus.fifo_full) check({name, ":we_while_full"}, 64'(bus.fifo_write_enable), 64'(0));
            if (held_ok) check({name, ":data_stable_stall"}, 64'(bus.fifo_data), 64'(held));
            held_ok = in_write && bus.fifo_full;
            held    = bus.fifo_data;
            if (bus.done) begin
                seen_done = 1'b1;
                check({name, ":done_after_last_write"}, 64'(prev_we), 64'(n > 0));
                check({name, ":busy_in_done"}, 64'(bus.busy), 64'(1));
            end
            prev_we = bus.fifo_write_enable;
        end

        if (!seen_done) check({name, ":timeout_waiting_done"}, 64'(0), 64'(1));
        check({name, ":bytes_accepted"}, 64'(ptr), 64'(n));
        check({name, ":write_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s:word%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
        end
        if (valid_pct >= 100 && full_pct == 0 && stall_cycles == 0) begin
            check({name, ":cycle_count"}, 64'(cycles), 64'(2 + n + exp_q.size()));
        end

        // Cycle after done: back in IDLE with done dropped.
        @(posedge write_clock);
        #1;
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.fifo_full  = 1'b0;
        @(negedge write_clock);
        check({name, ":idle_busy"}, 64'(bus.busy), 64'(0));
        check({name, ":idle_done"}, 64'(bus.done), 64'(0));
    endtask

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.block_size = '0;
        bus.byte_in    = '0;
        bus.byte_valid = 1'b0;
        bus.fifo_full  = 1'b0;

        repeat (3) @(posedge write_clock);
        @(negedge write_clock);
        check("reset:byte_ready", 64'(bus.byte_ready), 64'(0));
        check("reset:fifo_we", 64'(bus.fifo_write_enable), 64'(0));
        check("reset:busy", 64'(bus.busy), 64'(0));
        check("reset:done", 64'(bus.done), 64'(0));
        check("reset:fifo_data", 64'(bus.fifo_data), 64'(0));
        reset = 1'b0;

        run_transfer("two_words", seq_bytes(8'h01, 8), 100, 0, 0, 1'b0);
        run_transfer("partial", seq_bytes(8'hA0, 6), 100, 0, 0, 1'b0);
        run_transfer("full_stall", seq_bytes(8'h31, 4), 100, 0, 5, 1'b0);
        run_transfer("zero_len", seq_bytes(8'h00, 0), 100, 0, 0, 1'b0);

        // Abort an 8-byte transfer after three bytes.
        @(posedge write_clock);
        #1;
        bus.start      = 1'b1;
        bus.block_size = LB'(8);
        @(posedge write_clock);
        #1;
        bus.start      = 1'b0;
        bus.byte_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.byte_in = 8'(8'h01 + 8'(k));
            @(posedge write_clock);
            #1;
        end
        bus.byte_valid = 1'b0;
        check("abort:busy_before_reset", 64'(bus.busy), 64'(1));
        #2 reset = 1'b1;
        #1;
        check("abort:byte_ready", 64'(bus.byte_ready), 64'(0));
        check("abort:fifo_we", 64'(bus.fifo_write_enable), 64'(0));
        check("abort:busy", 64'(bus.busy), 64'(0));
        check("abort:done", 64'(bus.done), 64'(0));
        check("abort:fifo_data", 64'(bus.fifo_data), 64'(0));
        @(negedge write_clock);
        reset = 1'b0;
        run_transfer("after_abort", seq_bytes(8'h11, 4), 100, 0, 0, 1'b0);

        run_transfer("gappy_start", seq_bytes(8'h11, 4), 50, 0, 0, 1'b1);

        for (int t = 0; t < 25; t++) begin
            run_transfer($sformatf("rand%0d", t), rand_bytes(int'($urandom_range(1, 13))),
                         int'($urandom_range(40, 100)), int'($urandom_range(0, 50)),
                         int'($urandom_range(0, 3)), 1'($urandom_range(1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
